// File: rtl/sum_capture_pkg.sv
// Shared constants and the stored entry type for the sum capture FIFO.
package sum_capture_pkg;

  localparam int SUM_W_DEF  = 9;
  localparam int TAG_W_DEF  = 8;
  localparam int DEPTH_DEF  = 4;
  localparam int DROP_W_DEF = 8;

  // One buffered sample: adder sum tagged with the counter value seen with it.
  typedef struct packed {
    logic [SUM_W_DEF-1:0] sum;
    logic [TAG_W_DEF-1:0] tag;
  } cap_entry_t;

endpackage

// File: rtl/sum_capture_ptr.sv
// Read/write pointers and occupancy for the sum capture FIFO.
// Pointers wrap naturally; full/empty are decoded from the registered level.
module sum_capture_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  output logic [$clog2(DEPTH)-1:0] rd_ptr,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  // Advance pointers on each handshake and track the number of stored entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/sum_capture_fifo.sv
// Captures adder sums tagged with the counter value into a small
// first-word-fall-through FIFO drained over valid/ready. Samples arriving
// while full and stalled are dropped and flagged by a sticky overflow bit.
// Build option: define SUM_CAPTURE_DROP_CNT_EN to include the saturating
// drop counter; otherwise drop_count is tied to zero.
module sum_capture_fifo
  import sum_capture_pkg::*;
#(
  parameter int SUM_W  = SUM_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [SUM_W-1:0]         in_sum,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SUM_W-1:0]         out_sum,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic [DROP_W-1:0]        drop_count
);

  // Entry storage uses the package entry type, so SUM_W/TAG_W must stay at
  // the package defaults.
  logic [$clog2(DEPTH)-1:0] rd_ptr;
  logic [$clog2(DEPTH)-1:0] wr_ptr;
  logic                     push;
  logic                     pop;
  logic                     drop;
  logic                     overflow_reg;
  cap_entry_t               wr_entry;
  cap_entry_t               rd_entry;
  cap_entry_t               mem [DEPTH];

  // Handshake decode: a full FIFO still accepts a sample when it pops the head.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !out_ready;

  sum_capture_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .rd_ptr (rd_ptr),
    .wr_ptr (wr_ptr),
    .level  (level),
    .full   (full),
    .empty  (empty)
  );

  assign wr_entry.sum = in_sum;
  assign wr_entry.tag = in_tag;

  // Store accepted samples; contents are not reset, only the pointers are.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Head is read combinationally so a new entry shows one cycle after its write.
  assign rd_entry  = mem[rd_ptr];
  assign out_sum   = rd_entry.sum;
  assign out_tag   = rd_entry.tag;
  assign out_valid = !empty;

  // Sticky overflow flag; a clear wins over a drop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst)               overflow_reg <= 1'b0;
    else if (clr_overflow) overflow_reg <= 1'b0;
    else if (drop)         overflow_reg <= 1'b1;
  end

  assign overflow = overflow_reg;

`ifdef SUM_CAPTURE_DROP_CNT_EN
  logic [DROP_W-1:0] drop_count_reg;

  // Saturating count of dropped samples; cleared together with overflow.
  always_ff @(posedge clk) begin
    if (rst)                                drop_count_reg <= '0;
    else if (clr_overflow)                  drop_count_reg <= '0;
    else if (drop && (drop_count_reg != '1)) drop_count_reg <= drop_count_reg + 1'b1;
  end

  assign drop_count = drop_count_reg;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_sum_capture_fifo.sv
// Self-checking bench for sum_capture_fifo: directed scenarios plus random
// traffic, compared every cycle against a queue-based model.
module tb_sum_capture_fifo;

  localparam int DEPTH  = 4;
  localparam int SUM_W  = 9;
  localparam int TAG_W  = 8;
  localparam int DROP_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [SUM_W-1:0] in_sum;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [TAG_W-1:0] out_tag;
  logic             full;
  logic             empty;
  logic [2:0]       level;
  logic             overflow;
  logic             clr_overflow;
  logic [DROP_W-1:0] drop_count;

  sum_capture_fifo #(
    .SUM_W  (SUM_W),
    .TAG_W  (TAG_W),
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_sum       (in_sum),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sum      (out_sum),
    .out_tag      (out_tag),
    .full         (full),
    .empty        (empty),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: queue of {sum, tag}, sticky flag and drop tally.
  logic [SUM_W+TAG_W-1:0] q[$];
  bit m_ov  = 1'b0;
  int m_dc  = 0;

  function automatic int exp_dc();
`ifdef SUM_CAPTURE_DROP_CNT_EN
    return m_dc;
`else
    return 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented to it.
  task automatic model_step();
    int sz;
    bit m_pop, m_full, m_push, m_drop;
    sz     = q.size();
    m_pop  = (sz > 0) && out_ready;
    m_full = (sz == DEPTH);
    m_push = in_valid && (!m_full || m_pop);
    m_drop = in_valid && m_full && !out_ready;
    if (rst) begin
      q.delete();
      m_ov = 1'b0;
      m_dc = 0;
    end else begin
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back({in_sum, in_tag});
      if (clr_overflow) begin
        m_ov = 1'b0;
        m_dc = 0;
      end else if (m_drop) begin
        m_ov = 1'b1;
        if (m_dc < (1 << DROP_W) - 1) m_dc++;
      end
    end
  endtask

  // Compare process: all outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid",  int'(out_valid),  int'(q.size() > 0));
      chk("empty",      int'(empty),      int'(q.size() == 0));
      chk("full",       int'(full),       int'(q.size() == DEPTH));
      chk("level",      int'(level),      q.size());
      chk("overflow",   int'(overflow),   int'(m_ov));
      chk("drop_count", int'(drop_count), exp_dc());
      if (q.size() > 0) begin
        chk("out_sum", int'(out_sum), int'(q[0][SUM_W+TAG_W-1:TAG_W]));
        chk("out_tag", int'(out_tag), int'(q[0][TAG_W-1:0]));
      end
    end
  end

  // One clock: drive inputs, let the edge happen, return at negedge+1.
  task automatic cyc(input bit r, input bit v, input logic [SUM_W-1:0] s,
                     input logic [TAG_W-1:0] t, input bit rdy, input bit clr);
    rst          = r;
    in_valid     = v;
    in_sum       = s;
    in_tag       = t;
    out_ready    = rdy;
    clr_overflow = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [SUM_W-1:0] rs();
    return SUM_W'($urandom_range(0, (1 << SUM_W) - 1));
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_tag = '0;
    out_ready = 1'b0; clr_overflow = 1'b0;
    @(negedge clk);
    #1;
    chk_en = 1'b1;

    // Reset, then idle.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0);
    chk("lit_idle_out_valid", int'(out_valid), 0);
    chk("lit_idle_empty",     int'(empty),     1);
    chk("lit_idle_level",     int'(level),     0);
    chk("lit_idle_overflow",  int'(overflow),  0);

    // Single push with a stalled consumer: visible one cycle later.
    cyc(0, 1, 9'h1FE, 8'h05, 0, 0);
    chk("lit_one_out_valid", int'(out_valid), 1);
    chk("lit_one_out_sum",   int'(out_sum),   'h1FE);
    chk("lit_one_out_tag",   int'(out_tag),   'h05);
    chk("lit_one_level",     int'(level),     1);
    cyc(0, 0, 0, 0, 1, 0);

    // Fill with tags 1..4, then a fifth sample is dropped.
    for (int k = 1; k <= 5; k++) cyc(0, 1, rs(), TAG_W'(k), 0, 0);
    chk("lit_ovf_full",     int'(full),     1);
    chk("lit_ovf_level",    int'(level),    4);
    chk("lit_ovf_overflow", int'(overflow), 1);
`ifdef SUM_CAPTURE_DROP_CNT_EN
    chk("lit_ovf_drop_count", int'(drop_count), 1);
`else
    chk("lit_ovf_drop_count", int'(drop_count), 0);
`endif
    for (int k = 1; k <= 4; k++) begin
      chk("lit_drain_tag", int'(out_tag), k);
      cyc(0, 0, 0, 0, 1, 0);
    end
    chk("lit_drain_empty", int'(empty), 1);

    // Full FIFO with simultaneous push and pop for 6 cycles.
    cyc(0, 0, 0, 0, 0, 1);
    for (int k = 20; k <= 23; k++) cyc(0, 1, rs(), TAG_W'(k), 0, 0);
    for (int k = 10; k <= 15; k++) cyc(0, 1, rs(), TAG_W'(k), 1, 0);
    chk("lit_stream_level",    int'(level),    4);
    chk("lit_stream_overflow", int'(overflow), 0);
    chk("lit_stream_head_tag", int'(out_tag),  12);

    // Reset with entries queued discards them.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, rs(), TAG_W'(k + 40), 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("lit_rst_empty",     int'(empty),     1);
    chk("lit_rst_out_valid", int'(out_valid), 0);
    cyc(0, 1, rs(), 8'hAA, 0, 0);
    chk("lit_rst_head_tag", int'(out_tag), 'hAA);
    cyc(0, 0, 0, 0, 1, 0);

    // Saturation of the drop counter, then clear racing a drop.
    for (int k = 0; k < 4; k++) cyc(0, 1, rs(), TAG_W'(k), 0, 0);
    for (int i = 0; i < 300; i++) cyc(0, 1, rs(), TAG_W'($urandom_range(0, 255)), 0, 0);
`ifdef SUM_CAPTURE_DROP_CNT_EN
    chk("lit_sat_drop_count", int'(drop_count), 255);
`else
    chk("lit_sat_drop_count", int'(drop_count), 0);
`endif
    chk("lit_sat_overflow", int'(overflow), 1);
    cyc(0, 1, rs(), 8'h77, 0, 1);
    chk("lit_clr_overflow",   int'(overflow),   0);
    chk("lit_clr_drop_count", int'(drop_count), 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);

    // Random traffic with phases of heavy and light back-pressure.
    for (int i = 0; i < 4000; i++) begin
      bit r, v, rdy, clr;
      r   = ($urandom_range(0, 299) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      clr = ($urandom_range(0, 99) == 0);
      cyc(r, v, rs(), TAG_W'($urandom_range(0, 255)), rdy, clr);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
